// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: header ECC matrix, ECC helpers, header layout, parser states.
package csi2_pkg;

  localparam int HDR_BITS = 24;

  // Data types below this value are short packets (frame/line sync, generic short).
  localparam logic [5:0] SHORT_DT_LIMIT = 6'h10;

  // Hamming parity rows P5..P0 over the 24 header bits {WC[15:8], WC[7:0], DI}.
  // Packed so that ECC_MATRIX[r] is the bit mask feeding parity bit r.
  localparam logic [5:0][23:0] ECC_MATRIX = {
    24'hEFFC00,  // P5
    24'hDF03F0,  // P4
    24'hB8E38E,  // P3
    24'h749A6D,  // P2
    24'hF2555B,  // P1
    24'hF12CB7   // P0
  };

  // Header word as it arrives: byte 0 (DI) is first on the wire.
  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [7:0]  di;
  } csi2_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DONE
  } csi2_state_t;

  // ECC byte for a 24-bit header; the two top bits are always zero.
  function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
    logic [7:0] p;
    p = '0;
    for (int r = 0; r < 6; r++) begin
      p[r] = ^(d & ECC_MATRIX[r]);
    end
    return p;
  endfunction

  // Syndrome produced by a single error in header bit idx.
  function automatic logic [5:0] csi2_ecc_column(input int idx);
    logic [5:0] col;
    col = '0;
    for (int r = 0; r < 6; r++) begin
      col[r] = ECC_MATRIX[r][idx];
    end
    return col;
  endfunction

  // Syndrome to bit index: result is {hit, index[4:0]}; hit=0 when the
  // syndrome matches no single header-bit column.
  function automatic logic [5:0] csi2_syn_lookup(input logic [5:0] syn);
    logic [5:0] res;
    res = '0;
    for (int i = 0; i < HDR_BITS; i++) begin
      if (csi2_ecc_column(i) == syn) begin
        res = {1'b1, 5'(i)};
      end
    end
    return res;
  endfunction

  // Byte enables for a word that carries min(rem, 4) payload bytes.
  function automatic logic [3:0] csi2_keep_mask(input logic [15:0] rem);
    logic [3:0] k;
    if (rem >= 16'd4) begin
      k = 4'hF;
    end else begin
      case (rem[1:0])
        2'd1:    k = 4'h1;
        2'd2:    k = 4'h3;
        2'd3:    k = 4'h7;
        default: k = 4'h0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/csi2_hdr_ecc.sv
// Header ECC stage: computes the syndrome of the captured header word,
// corrects a single flipped header bit and registers the result (1-cycle latency).
module csi2_hdr_ecc
  import csi2_pkg::*;
(
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        i_stb,
  input  logic [31:0] i_word,
  output logic        o_valid,
  output logic [7:0]  o_di,
  output logic [15:0] o_wc,
  output logic        o_ok,
  output logic        o_corrected,
  output logic        o_err
);

  csi2_hdr_t   w_hdr_in;
  logic [23:0] w_bits;
  logic [5:0]  w_parity;
  logic [5:0]  w_syn;
  logic [5:0]  w_lookup;
  logic [23:0] w_flip;
  logic [23:0] w_fixed;
  logic        w_unused_rsvd;

  logic        r_valid;
  logic [7:0]  r_di;
  logic [15:0] r_wc;
  logic        r_ok;
  logic        r_corr;
  logic        r_err;

  assign w_hdr_in = csi2_hdr_t'(i_word);
  assign w_bits   = {w_hdr_in.wc, w_hdr_in.di};

  genvar gi;

  generate
    for (gi = 0; gi < 6; gi++) begin : g_parity
      assign w_parity[gi] = ^(w_bits & ECC_MATRIX[gi]);
    end
  endgenerate

  // Reserved ECC bits 7:6 take no part in the syndrome.
  assign w_syn         = w_parity ^ w_hdr_in.ecc[5:0];
  assign w_unused_rsvd = ^w_hdr_in.ecc[7:6];
  assign w_lookup      = csi2_syn_lookup(w_syn);

  generate
    for (gi = 0; gi < HDR_BITS; gi++) begin : g_flip
      assign w_flip[gi] = w_lookup[5] && (w_lookup[4:0] == 5'(gi));
    end
  endgenerate

  assign w_fixed = w_bits ^ w_flip;

  // Capture the corrected header and its classification when strobed.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_valid <= 1'b0;
      r_di    <= '0;
      r_wc    <= '0;
      r_ok    <= 1'b0;
      r_corr  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= i_stb;
      if (i_stb) begin
        r_di   <= w_fixed[7:0];
        r_wc   <= w_fixed[23:8];
        r_ok   <= (w_syn == 6'd0);
        r_corr <= w_lookup[5];
        r_err  <= (w_syn != 6'd0) && !w_lookup[5];
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_di        = r_di;
  assign o_wc        = r_wc;
  assign o_ok        = r_valid & r_ok;
  assign o_corrected = r_valid & r_corr;
  assign o_err       = r_valid & r_err;

endmodule

// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet parser on the byte clock: header capture/ECC, payload
// forwarding with byte enables, CRC stripping, gap timeout and end-of-packet pulse.
module csi2_pkt_parser
  import csi2_pkg::*;
#(
  parameter int GAP_TIMEOUT = 64
)
(
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic [31:0] data_o,
  output logic [3:0]  keep_o,
  output logic        valid_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic        hdr_valid_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic        short_pkt_o,
  output logic        ecc_corrected_o,
  output logic        ecc_err_o,
  output logic        trunc_err_o,
  output logic        pkt_done_o
);

  localparam int               GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  csi2_state_t      r_state;
  csi2_state_t      w_state_next;
  logic [15:0]      r_pay_rem;
  logic [15:0]      w_pay_next;
  logic [15:0]      w_pay_cur;
  logic [16:0]      r_tot_rem;
  logic [16:0]      w_tot_next;
  logic [16:0]      w_tot_cur;
  logic             r_first;
  logic             w_first_next;
  logic             w_first_cur;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_next;
  logic             w_take;

  logic [31:0]      r_data;
  logic [31:0]      w_data_next;
  logic [3:0]       r_keep;
  logic [3:0]       w_keep_next;
  logic             r_valid;
  logic             w_valid_next;
  logic             r_sop;
  logic             w_sop_next;
  logic             r_eop;
  logic             w_eop_next;
  logic             r_trunc;
  logic             w_trunc_next;
  logic             r_done;
  logic             w_done_next;

  logic             w_hdr_stb;
  logic             w_hdr_valid;
  logic [7:0]       w_hdr_di;
  logic [15:0]      w_hdr_wc;
  logic             w_hdr_ok;
  logic             w_hdr_corr;
  logic             w_hdr_err;
  logic             w_hdr_good;
  logic             w_short;

  // The first valid word seen in IDLE is the packet header.
  assign w_hdr_stb = (r_state == ST_IDLE) && valid_i;

  csi2_hdr_ecc u_hdr_ecc (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .i_stb       (w_hdr_stb),
    .i_word      (data_i),
    .o_valid     (w_hdr_valid),
    .o_di        (w_hdr_di),
    .o_wc        (w_hdr_wc),
    .o_ok        (w_hdr_ok),
    .o_corrected (w_hdr_corr),
    .o_err       (w_hdr_err)
  );

  assign w_hdr_good = w_hdr_ok || w_hdr_corr;
  assign w_short    = (w_hdr_di[5:0] < SHORT_DT_LIMIT);

  // Next-state, counter and output-register logic.
  always_comb begin
    w_state_next = r_state;
    w_pay_cur    = r_pay_rem;
    w_tot_cur    = r_tot_rem;
    w_first_cur  = r_first;
    w_pay_next   = r_pay_rem;
    w_tot_next   = r_tot_rem;
    w_first_next = r_first;
    w_gap_next   = r_gap;
    w_take       = 1'b0;
    w_data_next  = r_data;
    w_keep_next  = 4'h0;
    w_valid_next = 1'b0;
    w_sop_next   = 1'b0;
    w_eop_next   = 1'b0;
    w_trunc_next = 1'b0;
    w_done_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (valid_i) begin
          w_state_next = ST_HDR;
        end
      end

      ST_HDR: begin
        // Header fields are out of the ECC stage this cycle; a payload word
        // arriving in the same cycle is consumed against the fresh counters.
        if (!w_hdr_good || w_short) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_pay_cur    = w_hdr_wc;
          w_tot_cur    = {1'b0, w_hdr_wc} + 17'd2;
          w_first_cur  = 1'b1;
          w_pay_next   = w_pay_cur;
          w_tot_next   = w_tot_cur;
          w_first_next = 1'b1;
          w_gap_next   = '0;
          w_state_next = ST_PAYLOAD;
          w_take       = valid_i;
        end
      end

      ST_PAYLOAD: begin
        if (valid_i) begin
          w_take     = 1'b1;
          w_gap_next = '0;
        end else if (r_gap == GAP_LAST) begin
          w_gap_next   = '0;
          w_trunc_next = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_gap_next = r_gap + 1'b1;
        end
      end

      ST_DONE: begin
        // Swallow trailer words until the stream goes quiet for one cycle.
        if (!valid_i) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_take) begin
      if (w_pay_cur != 16'd0) begin
        w_valid_next = 1'b1;
        w_data_next  = data_i;
        w_keep_next  = csi2_keep_mask(w_pay_cur);
        w_sop_next   = w_first_cur;
        w_eop_next   = (w_pay_cur <= 16'd4);
      end
      w_first_next = 1'b0;
      w_pay_next   = (w_pay_cur > 16'd4) ? (w_pay_cur - 16'd4) : 16'd0;
      w_tot_next   = (w_tot_cur > 17'd4) ? (w_tot_cur - 17'd4) : 17'd0;
      if (w_tot_cur <= 17'd4) begin
        w_state_next = ST_DONE;
        w_done_next  = 1'b1;
      end
    end
  end

  // State, counters and registered outputs; reset wins over every transition.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state   <= ST_IDLE;
      r_pay_rem <= '0;
      r_tot_rem <= '0;
      r_first   <= 1'b0;
      r_gap     <= '0;
      r_data    <= '0;
      r_keep    <= '0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_trunc   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pay_rem <= w_pay_next;
      r_tot_rem <= w_tot_next;
      r_first   <= w_first_next;
      r_gap     <= w_gap_next;
      r_data    <= w_data_next;
      r_keep    <= w_keep_next;
      r_valid   <= w_valid_next;
      r_sop     <= w_sop_next;
      r_eop     <= w_eop_next;
      r_trunc   <= w_trunc_next;
      r_done    <= w_done_next;
    end
  end

  assign data_o          = r_data;
  assign keep_o          = r_keep;
  assign valid_o         = r_valid;
  assign sop_o           = r_sop;
  assign eop_o           = r_eop;
  assign trunc_err_o     = r_trunc;
  assign pkt_done_o      = r_done;

  assign hdr_valid_o     = w_hdr_valid && w_hdr_good;
  assign vc_o            = w_hdr_di[7:6];
  assign dt_o            = w_hdr_di[5:0];
  assign wc_o            = w_hdr_wc;
  assign short_pkt_o     = hdr_valid_o && w_short;
  assign ecc_corrected_o = w_hdr_corr;
  assign ecc_err_o       = w_hdr_err;

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// Directed bench for csi2_pkt_parser: header ECC cases, long packets with and
// without gaps, odd word counts, truncation timeout and mid-packet reset.
module tb_csi2_pkt_parser;

  logic        clk = 1'b0;
  logic        srst_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        valid_o;
  logic        sop_o;
  logic        eop_o;
  logic        hdr_valid_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o;
  logic        short_pkt_o;
  logic        ecc_corrected_o;
  logic        ecc_err_o;
  logic        trunc_err_o;
  logic        pkt_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  csi2_pkt_parser #(.GAP_TIMEOUT(64)) dut (
    .clk_i           (clk),
    .srst_i          (srst_i),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .data_o          (data_o),
    .keep_o          (keep_o),
    .valid_o         (valid_o),
    .sop_o           (sop_o),
    .eop_o           (eop_o),
    .hdr_valid_o     (hdr_valid_o),
    .vc_o            (vc_o),
    .dt_o            (dt_o),
    .wc_o            (wc_o),
    .short_pkt_o     (short_pkt_o),
    .ecc_corrected_o (ecc_corrected_o),
    .ecc_err_o       (ecc_err_o),
    .trunc_err_o     (trunc_err_o),
    .pkt_done_o      (pkt_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    data_i  = w;
    valid_i = 1'b1;
    tick();
  endtask

  task automatic idle();
    data_i  = 32'h0;
    valid_i = 1'b0;
    tick();
  endtask

  // Check one forwarded payload word.
  task automatic chk_pay(input string tag, input logic [31:0] d, input logic [3:0] k,
                         input logic s, input logic e);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_data"},  data_o,       d);
    chk({tag, "_keep"},  32'(keep_o),  32'(k));
    chk({tag, "_sop"},   32'(sop_o),   32'(s));
    chk({tag, "_eop"},   32'(eop_o),   32'(e));
  endtask

  initial begin
    srst_i  = 1'b1;
    valid_i = 1'b0;
    data_i  = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_data", data_o, 32'h0);
    chk("rst_flags", 32'({keep_o, valid_o, sop_o, eop_o, hdr_valid_o, vc_o, dt_o,
                          short_pkt_o, ecc_corrected_o, ecc_err_o, trunc_err_o, pkt_done_o}), 32'h0);
    chk("rst_wc", 32'(wc_o), 32'h0);
    srst_i = 1'b0;
    idle();
    $display("tb: reset released");

    // Short packet: frame start, VC0, ECC 0x00
    send(32'h0000_0000);
    chk("sp_hdr_valid", 32'(hdr_valid_o), 32'd1);
    chk("sp_dt", 32'(dt_o), 32'h00);
    chk("sp_wc", 32'(wc_o), 32'h0);
    chk("sp_short", 32'(short_pkt_o), 32'd1);
    chk("sp_ecc_flags", 32'({ecc_corrected_o, ecc_err_o}), 32'h0);
    chk("sp_done_early", 32'(pkt_done_o), 32'd0);
    idle();
    chk("sp_done", 32'(pkt_done_o), 32'd1);
    chk("sp_no_valid", 32'(valid_o), 32'd0);
    chk("sp_hdr_pulse", 32'(hdr_valid_o), 32'd0);
    idle();
    chk("sp_done_pulse", 32'(pkt_done_o), 32'd0);
    $display("tb: short packet");

    // Long packet DT 0x2B WC 6, ECC 0x28
    send(32'h2800_062B);
    chk("lp6_hdr_valid", 32'(hdr_valid_o), 32'd1);
    chk("lp6_fields", 32'({vc_o, dt_o, wc_o}), 32'({2'd0, 6'h2B, 16'd6}));
    chk("lp6_short", 32'(short_pkt_o), 32'd0);
    chk("lp6_corr", 32'(ecc_corrected_o), 32'd0);
    send(32'h4433_2211);
    chk_pay("lp6_w0", 32'h4433_2211, 4'hF, 1'b1, 1'b0);
    chk("lp6_w0_done", 32'(pkt_done_o), 32'd0);
    send(32'hCCBB_6655);
    chk_pay("lp6_w1", 32'hCCBB_6655, 4'h3, 1'b0, 1'b1);
    chk("lp6_done", 32'(pkt_done_o), 32'd1);
    idle();
    chk("lp6_after", 32'({valid_o, pkt_done_o}), 32'h0);
    idle();
    $display("tb: long packet wc=6");

    // Single-bit corrected header (bit 0 flipped)
    send(32'h0000_0001);
    chk("cor_flag", 32'(ecc_corrected_o), 32'd1);
    chk("cor_hdr_valid", 32'(hdr_valid_o), 32'd1);
    chk("cor_fields", 32'({dt_o, wc_o}), 32'h0);
    chk("cor_short", 32'(short_pkt_o), 32'd1);
    chk("cor_err", 32'(ecc_err_o), 32'd0);
    idle();
    chk("cor_done", 32'(pkt_done_o), 32'd1);
    chk("cor_flag_pulse", 32'(ecc_corrected_o), 32'd0);
    idle();
    $display("tb: corrected header");

    // Uncorrectable header
    send(32'h0000_0003);
    chk("unc_err", 32'(ecc_err_o), 32'd1);
    chk("unc_hdr_valid", 32'(hdr_valid_o), 32'd0);
    chk("unc_corr", 32'(ecc_corrected_o), 32'd0);
    send(32'hDEAD_BEEF);
    chk("unc_done", 32'(pkt_done_o), 32'd1);
    chk("unc_no_pay", 32'(valid_o), 32'd0);
    chk("unc_err_pulse", 32'(ecc_err_o), 32'd0);
    idle();
    chk("unc_quiet", 32'({valid_o, pkt_done_o}), 32'h0);
    idle();
    $display("tb: uncorrectable header");

    // WC 8 (ECC 0x32): gapless, then one word per 3 cycles; outputs must match
    for (int g = 0; g < 2; g++) begin
      send(32'h3200_082B);
      chk("wc8_hdr", 32'({hdr_valid_o, wc_o}), 32'({1'b1, 16'd8}));
      repeat (2 * g) begin idle(); chk("wc8_gap", 32'(valid_o), 32'd0); end
      send(32'h0302_0100);
      chk_pay("wc8_w0", 32'h0302_0100, 4'hF, 1'b1, 1'b0);
      repeat (2 * g) begin idle(); chk("wc8_gap", 32'(valid_o), 32'd0); end
      send(32'h0706_0504);
      chk_pay("wc8_w1", 32'h0706_0504, 4'hF, 1'b0, 1'b1);
      chk("wc8_w1_done", 32'(pkt_done_o), 32'd0);
      repeat (2 * g) begin idle(); chk("wc8_gap", 32'(valid_o), 32'd0); end
      send(32'hA5A5_5A5A);
      chk("wc8_crc_valid", 32'(valid_o), 32'd0);
      chk("wc8_done", 32'(pkt_done_o), 32'd1);
      idle();
      idle();
      $display("tb: long packet wc=8 gap=%0d", 2 * g);
    end

    // WC 7 (ECC 0x32): second word keeps 3 bytes, CRC-only word consumed silently
    send(32'h3200_072B);
    chk("wc7_hdr", 32'({hdr_valid_o, wc_o}), 32'({1'b1, 16'd7}));
    send(32'h1312_1110);
    chk_pay("wc7_w0", 32'h1312_1110, 4'hF, 1'b1, 1'b0);
    send(32'hC016_1514);
    chk_pay("wc7_w1", 32'hC016_1514, 4'h7, 1'b0, 1'b1);
    chk("wc7_w1_done", 32'(pkt_done_o), 32'd0);
    send(32'h0000_00C1);
    chk("wc7_crc_valid", 32'(valid_o), 32'd0);
    chk("wc7_done", 32'(pkt_done_o), 32'd1);
    idle();
    idle();
    $display("tb: long packet wc=7");

    // Truncation: WC 100 (ECC 0x37), stop after two payload words
    send(32'h3700_642B);
    chk("tr_hdr", 32'({hdr_valid_o, wc_o}), 32'({1'b1, 16'd100}));
    send(32'h2322_2120);
    chk_pay("tr_w0", 32'h2322_2120, 4'hF, 1'b1, 1'b0);
    send(32'h2726_2524);
    chk_pay("tr_w1", 32'h2726_2524, 4'hF, 1'b0, 1'b0);
    for (int k = 1; k < 64; k++) begin
      idle();
      chk("tr_early", 32'({valid_o, eop_o, trunc_err_o, pkt_done_o}), 32'h0);
    end
    idle();
    chk("tr_trunc", 32'(trunc_err_o), 32'd1);
    chk("tr_done", 32'(pkt_done_o), 32'd1);
    chk("tr_no_eop", 32'({valid_o, eop_o}), 32'h0);
    idle();
    chk("tr_pulse", 32'({trunc_err_o, pkt_done_o}), 32'h0);
    $display("tb: truncated packet");

    // Reset mid-payload, then a normal packet
    send(32'h3700_642B);
    send(32'h3332_3130);
    chk_pay("rs_w0", 32'h3332_3130, 4'hF, 1'b1, 1'b0);
    srst_i  = 1'b1;
    data_i  = 32'h5566_7788;
    valid_i = 1'b1;
    tick();
    chk("rs_data", data_o, 32'h0);
    chk("rs_flags", 32'({keep_o, valid_o, sop_o, eop_o, hdr_valid_o, vc_o, dt_o,
                         short_pkt_o, ecc_corrected_o, ecc_err_o, trunc_err_o, pkt_done_o}), 32'h0);
    chk("rs_wc", 32'(wc_o), 32'h0);
    srst_i = 1'b0;
    idle();
    chk("rs_quiet", 32'({valid_o, pkt_done_o, hdr_valid_o}), 32'h0);
    send(32'h2800_062B);
    chk("rs_hdr", 32'({hdr_valid_o, dt_o, wc_o}), 32'({1'b1, 6'h2B, 16'd6}));
    send(32'h4443_4241);
    chk_pay("rs_w1", 32'h4443_4241, 4'hF, 1'b1, 1'b0);
    send(32'hEEDD_4645);
    chk_pay("rs_w2", 32'hEEDD_4645, 4'h3, 1'b0, 1'b1);
    chk("rs_done", 32'(pkt_done_o), 32'd1);
    idle();
    idle();
    $display("tb: reset mid-packet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csi2_pkt_parser.md
Name: csi2_pkt_parser

Overview:
- Sits directly downstream of the D-PHY slave, on the byte clock.
- Consumes the 32-bit lane-mapped word stream, captures and ECC-checks the CSI-2 packet header, and forwards long-packet payload with per-byte enables; the CRC bytes are stripped.
- Detects end of packet from the word count and pulses pkt_done_o, which drives the PHY's phy_rst_i/eop input to re-arm byte/word alignment for the next HS burst.

Parameters:
- GAP_TIMEOUT, 64, byte-clock cycles without valid_i inside a packet before it is declared truncated.

Ports:
- clk_i  in  1  byte clock (PHY clk_o).
- srst_i  in  1  synchronous active-high reset.
- data_i  in  32  mapped word; byte0 = bits 7:0 is first on the wire.
- valid_i  in  1  data_i qualifier; gaps between valid words are legal.
- data_o  out  32  payload word, same byte order as data_i.
- keep_o  out  4  byte enables for data_o, bit n = byte n.
- valid_o  out  1  payload qualifier.
- sop_o  out  1  first payload word of the packet.
- eop_o  out  1  last payload word of the packet.
- hdr_valid_o  out  1  one-cycle pulse: header fields below are valid.
- vc_o  out  2  virtual channel, DI[7:6].
- dt_o  out  6  data type, DI[5:0].
- wc_o  out  16  word count, or short-packet data field.
- short_pkt_o  out  1  dt_o < 0x10 (qualified by hdr_valid_o).
- ecc_corrected_o  out  1  one-cycle pulse: single-bit header error corrected.
- ecc_err_o  out  1  one-cycle pulse: uncorrectable header.
- trunc_err_o  out  1  one-cycle pulse: gap timeout inside a packet.
- pkt_done_o  out  1  one-cycle pulse: packet ended; PHY must realign.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Header layout: first valid word = {ECC[7:0], WC[15:8], WC[7:0], DI}.
  - 6-bit syndrome = ECC[5:0] XOR Hamming parity of the 24 header bits (CSI-2 matrix).
  - Syndrome 0 → header OK.
  - Syndrome equal to a single matrix column → that bit is flipped, ecc_corrected_o pulses.
  - Any other syndrome → ecc_err_o pulses.
- IDLE:
  - First valid_i word is registered as the header.
  - Next cycle: hdr_valid_o pulses with corrected fields, plus the ecc flag if any.
  - Uncorrectable header → DONE; no hdr_valid_o.
  - Short packet → DONE.
  - Long packet → PAYLOAD, with pay_rem = WC and tot_rem = WC + 2 (17-bit).
- PAYLOAD:
  - Each valid word: if pay_rem > 0, output it one cycle later.
    - valid_o = 1.
    - keep_o = low min(pay_rem, 4) bits set.
    - sop_o on the first payload word.
    - eop_o when pay_rem ≤ 4.
  - Both counters decrement by 4, saturating at 0.
  - Words carrying only CRC bytes are consumed, not output.
  - When tot_rem ≤ 4 on a valid word → DONE.
  - WC = 0: one CRC word, no valid_o, no sop_o/eop_o.
- Gap counter:
  - Clears on every valid_i, increments otherwise in PAYLOAD.
  - Reaching GAP_TIMEOUT → trunc_err_o pulses, → DONE.
  - A partial packet is never closed with eop_o; the downstream consumer discards on trunc_err_o.
- DONE:
  - pkt_done_o pulses on the entry cycle.
  - Words are then discarded until valid_i is 0 for one cycle, then IDLE.
  - This absorbs trailer/garbage after EoT.
- Latency: header fields 1 cycle after the header word; payload 1 cycle after the input word; pkt_done_o 1 cycle after the last word.
- srst_i mid-packet: immediate return to IDLE, no pulses emitted, partial packet dropped.
- srst_i has priority over every transition.

Decomposition:
- csi2_pkg holds:
  - ECC parity matrix constant (6 × 24).
  - Function csi2_ecc(24-bit) → 8-bit.
  - Syndrome-to-bit-index lookup.
  - Short-packet DT boundary 0x10.
  - Typedef csi2_hdr_t {di, wc, ecc}.
- Sub-module csi2_hdr_ecc: registered syndrome computation and single-bit correction, 1-cycle latency, outputs the corrected header plus ok/corrected/err flags.

Test Plan:
- Short packet: word 0x00000000 (FS, VC0, ECC 0x00) → hdr_valid_o with dt 0x00, wc 0, short_pkt_o=1; pkt_done_o 1 cycle later; valid_o never asserts.
- Long packet: DT 0x2B, WC 6, ECC via csi2_ecc; words P0..P3, P4 P5 C0 C1 → data_o words:
  - first: keep 0xF, sop_o.
  - second: keep 0x3, eop_o.
  - then pkt_done_o.
- Corrected header: 0x00000001 (bit 0 flipped from all-zero) → ecc_corrected_o, dt 0x00, wc 0; treated as short packet.
- Uncorrectable header: 0x00000003 → ecc_err_o, no hdr_valid_o, pkt_done_o, no payload.
- Gaps: WC 8 fed one word per 3 cycles → identical output to the gapless case.
- Truncation: WC 100 with valid_i stopped after 2 payload words → trunc_err_o exactly GAP_TIMEOUT cycles after the last word, no eop_o.
- Reset: srst_i mid-payload → all outputs 0 next cycle; the next header parses normally.
- WC mod 4 = 3: WC 7 → second payload word keep 0x7 with eop_o; the following CRC-only word is consumed silently before pkt_done_o.
